// File: rtl/johnson_pkg.sv
// Shared definitions for the Johnson counter and its downstream consumers.
package johnson_pkg;

   localparam int unsigned JOHNSON_WIDTH_DEF = 4;
   localparam int unsigned JOHNSON_MAXW      = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_LOCKED = 2'd2
   } jstate_t;

   // Next Johnson code: shift left, inverted MSB into the LSB.
   // Only the low w bits of code and of the result are meaningful.
   function automatic logic [JOHNSON_MAXW-1:0] johnson_next(
      input logic [JOHNSON_MAXW-1:0] code,
      input int unsigned             w
   );
      logic [JOHNSON_MAXW-1:0] mask;
      logic [JOHNSON_MAXW-1:0] nxt;
      mask = (w >= JOHNSON_MAXW) ? '1 : ((JOHNSON_MAXW'(1) << w) - JOHNSON_MAXW'(1));
      nxt  = (code << 1) | {{(JOHNSON_MAXW-1){1'b0}}, ~code[w-1]};
      return nxt & mask;
   endfunction

endpackage

// File: rtl/johnson_code_check.sv
// Combinational legality check and phase decode of one Johnson code.
module johnson_code_check
   import johnson_pkg::*;
#(
   parameter int WIDTH = JOHNSON_WIDTH_DEF,
   parameter int IDXW  = $clog2(2*WIDTH)
) (
   input  logic [WIDTH-1:0]   code,
   output logic               legal,
   output logic [IDXW-1:0]    idx,
   output logic [2*WIDTH-1:0] phase
);

   logic [WIDTH-1:0] ncode;
   logic [WIDTH-1:0] lo_tst;
   logic [WIDTH-1:0] hi_tst;
   int unsigned      ones;

   // A code is legal when its ones (or its zeros) form one contiguous run
   // anchored at the LSB; x & (x+1) == 0 detects a 0..01..1 pattern.
   always_comb begin
      ncode  = ~code;
      lo_tst = code & (code + WIDTH'(1));
      hi_tst = ncode & (ncode + WIDTH'(1));
      legal  = (lo_tst == '0) || (hi_tst == '0);
   end

   // Index: popcount on the rising half, WIDTH + zero count on the falling half.
   always_comb begin
      ones = 0;
      for (int i = 0; i < WIDTH; i++) ones += 32'(code[i]);
      if (code[WIDTH-1]) idx = IDXW'(2*WIDTH - int'(ones));
      else               idx = IDXW'(ones);
      phase = legal ? ((2*WIDTH)'(1) << idx) : '0;
   end

endmodule

// File: rtl/johnson_phase_decoder.sv
// Registers the decoded Johnson phase and tracks sequencing health
// with a lock FSM and a saturating error counter.
module johnson_phase_decoder
   import johnson_pkg::*;
#(
   parameter int WIDTH    = JOHNSON_WIDTH_DEF,
   parameter int LOCK_LEN = 4,
   parameter int IDXW     = $clog2(2*WIDTH)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [WIDTH-1:0]   count_in,
   input  logic               in_valid,
   output logic [2*WIDTH-1:0] phase,
   output logic [IDXW-1:0]    phase_idx,
   output logic               legal,
   output logic               step_err,
   output logic               locked,
   output logic [7:0]         err_cnt
);

   localparam int GW = $clog2(LOCK_LEN+1);

   jstate_t             state;
   logic [WIDTH-1:0]    prev_code;
   logic [GW-1:0]       good;
   logic [GW-1:0]       good_nx;
   logic [WIDTH-1:0]    exp_code;
   logic                c_legal;
   logic [IDXW-1:0]     c_idx;
   logic [2*WIDTH-1:0]  c_phase;
   logic [7:0]          err_inc;

   johnson_code_check #(.WIDTH(WIDTH), .IDXW(IDXW)) u_chk (
      .code  (count_in),
      .legal (c_legal),
      .idx   (c_idx),
      .phase (c_phase)
   );

   // Expected code and saturating increments feeding the registers.
   always_comb begin
      exp_code = WIDTH'(johnson_next(JOHNSON_MAXW'(prev_code), WIDTH));
      good_nx  = (good >= GW'(LOCK_LEN)) ? good : good + GW'(1);
      err_inc  = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
   end

   // Lock FSM plus all registered outputs; idle edges only drop step_err.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         prev_code <= '0;
         good      <= '0;
         phase     <= '0;
         phase_idx <= '0;
         legal     <= 1'b0;
         step_err  <= 1'b0;
         locked    <= 1'b0;
         err_cnt   <= '0;
      end else if (!in_valid) begin
         step_err <= 1'b0;
      end else if (!c_legal) begin
         // Illegal code: phase blanks, index holds, tracking restarts.
         legal    <= 1'b0;
         phase    <= '0;
         step_err <= 1'b1;
         err_cnt  <= err_inc;
         state    <= ST_IDLE;
         locked   <= 1'b0;
         good     <= '0;
      end else begin
         legal     <= 1'b1;
         phase     <= c_phase;
         phase_idx <= c_idx;
         prev_code <= count_in;
         if (state == ST_IDLE) begin
            // First legal sample has no history to compare against.
            step_err <= 1'b0;
            state    <= ST_SEARCH;
            good     <= '0;
            locked   <= 1'b0;
         end else if (count_in == exp_code) begin
            step_err <= 1'b0;
            good     <= good_nx;
            if (good_nx == GW'(LOCK_LEN)) begin
               state  <= ST_LOCKED;
               locked <= 1'b1;
            end
         end else begin
            // Stall or skip.
            step_err <= 1'b1;
            err_cnt  <= err_inc;
            good     <= '0;
            state    <= ST_SEARCH;
            locked   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Directed bench for johnson_phase_decoder (WIDTH=4, LOCK_LEN=4).
module tb_johnson_phase_decoder;

   logic       clk;
   logic       reset;
   logic [3:0] count_in;
   logic       in_valid;
   logic [7:0] phase;
   logic [2:0] phase_idx;
   logic       legal;
   logic       step_err;
   logic       locked;
   logic [7:0] err_cnt;

   int checks   = 0;
   int failures = 0;

   johnson_phase_decoder #(.WIDTH(4), .LOCK_LEN(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .count_in  (count_in),
      .in_valid  (in_valid),
      .phase     (phase),
      .phase_idx (phase_idx),
      .legal     (legal),
      .step_err  (step_err),
      .locked    (locked),
      .err_cnt   (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one sample on the falling edge, let it clock in, settle 1 ns.
   task automatic step(input logic [3:0] code, input logic v);
      @(negedge clk);
      count_in = code;
      in_valid = v;
      @(posedge clk);
      #1;
   endtask

   // Valid sample followed by decode, error and lock checks.
   task automatic samp(input logic [3:0] code, input int idx, input logic serr,
                       input logic lk, input string tag);
      step(code, 1'b1);
      chk({tag, "_idx"},   32'(phase_idx), 32'(idx));
      chk({tag, "_phase"}, 32'(phase),     32'(8'd1 << idx));
      chk({tag, "_serr"},  32'(step_err),  32'(serr));
      chk({tag, "_lock"},  32'(locked),    32'(lk));
   endtask

   logic [3:0] seq [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                           4'b1111, 4'b1110, 4'b1100, 4'b1000};

   initial begin
      reset    = 1'b0;
      count_in = '0;
      in_valid = 1'b0;
      #20;
      chk("rst_phase", 32'(phase),     0);
      chk("rst_idx",   32'(phase_idx), 0);
      chk("rst_legal", 32'(legal),     0);
      chk("rst_serr",  32'(step_err),  0);
      chk("rst_lock",  32'(locked),    0);
      chk("rst_err",   32'(err_cnt),   0);
      @(negedge clk);
      reset = 1'b1;

      // Free-run from 0000: lock on the 5th valid sample.
      for (int i = 0; i < 8; i++)
         samp(seq[i], i, 1'b0, (i >= 4), $sformatf("run%0d", i));
      samp(4'b0000, 0, 1'b0, 1'b1, "wrap");
      chk("run_err", 32'(err_cnt), 0);

      // Illegal code while locked.
      step(4'b0101, 1'b1);
      chk("ill_legal", 32'(legal),     0);
      chk("ill_phase", 32'(phase),     0);
      chk("ill_idx",   32'(phase_idx), 0);
      chk("ill_serr",  32'(step_err),  1);
      chk("ill_err",   32'(err_cnt),   1);
      chk("ill_lock",  32'(locked),    0);
      samp(4'b0011, 2, 1'b0, 1'b0, "res0");
      chk("res_legal", 32'(legal), 1);
      samp(4'b0111, 3, 1'b0, 1'b0, "res1");
      samp(4'b1111, 4, 1'b0, 1'b0, "res2");
      samp(4'b1110, 5, 1'b0, 1'b0, "res3");
      samp(4'b1100, 6, 1'b0, 1'b1, "res4");

      // Stall while locked.
      samp(4'b1100, 6, 1'b1, 1'b0, "stall");
      chk("stall_err", 32'(err_cnt), 2);

      // Skip 0001 -> 0111.
      samp(4'b1000, 7, 1'b0, 1'b0, "pre0");
      samp(4'b0000, 0, 1'b0, 1'b0, "pre1");
      samp(4'b0001, 1, 1'b0, 1'b0, "pre2");
      samp(4'b0111, 3, 1'b1, 1'b0, "skip");
      chk("skip_err", 32'(err_cnt), 3);

      // in_valid low: outputs frozen, step_err drops.
      step(4'b0101, 1'b0);
      chk("hold_serr", 32'(step_err), 0);
      step(4'b1111, 1'b0);
      step(4'b0000, 1'b0);
      chk("hold_idx",   32'(phase_idx), 3);
      chk("hold_phase", 32'(phase),     32'h08);
      chk("hold_legal", 32'(legal),     1);
      chk("hold_err",   32'(err_cnt),   3);
      samp(4'b1111, 4, 1'b0, 1'b0, "resume");

      // Saturate the error counter with alternating illegal codes.
      for (int i = 0; i < 300; i++)
         step((i % 2 == 0) ? 4'b0101 : 4'b1010, 1'b1);
      chk("sat_err",   32'(err_cnt),  255);
      chk("sat_legal", 32'(legal),    0);
      chk("sat_serr",  32'(step_err), 1);

      // Async reset mid-cycle, no clock edge in between.
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk("arst_phase", 32'(phase),     0);
      chk("arst_idx",   32'(phase_idx), 0);
      chk("arst_legal", 32'(legal),     0);
      chk("arst_serr",  32'(step_err),  0);
      chk("arst_lock",  32'(locked),    0);
      chk("arst_err",   32'(err_cnt),   0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
